// File: rtl/eth_10g_block_sync.sv
// rtl/eth_10g_block_sync.sv - 10GBASE-R block-lock synchroniser with rxslip control and 1-cycle passthrough
module eth_10g_block_sync #(
    parameter int DATA_WIDTH       = 32,
    parameter int LOCK_COUNT       = 64,
    parameter int INVALID_LIMIT    = 16,
    parameter int SLIP_WAIT_CYCLES = 32,
    parameter int SLIP_COUNT_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_WIDTH-1:0]       i_rxdata,
    input  logic                        i_rxdatavalid,
    input  logic [1:0]                  i_rxheader,
    input  logic                        i_rxheader_valid,
    output logic                        o_rxslip,
    output logic                        o_block_lock,
    output logic [DATA_WIDTH-1:0]       o_rxdata,
    output logic                        o_rxdatavalid,
    output logic [1:0]                  o_rxheader,
    output logic                        o_rxheader_valid,
    output logic [SLIP_COUNT_WIDTH-1:0] o_slip_count
);

    localparam int SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int INV_W  = $clog2(INVALID_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

    localparam logic [SH_W-1:0]   LOCK_MAX  = SH_W'(LOCK_COUNT);
    localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(INVALID_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_TEST = 2'd0,
        ST_SLIP = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        lock_q, lock_d;
    logic [SH_W-1:0]             sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]            inv_cnt_q, inv_cnt_d;
    logic [WAIT_W-1:0]           wait_cnt_q, wait_cnt_d;
    logic                        slip_q, slip_d;
    logic [SLIP_COUNT_WIDTH-1:0] slip_cnt_q, slip_cnt_d;
    logic [DATA_WIDTH-1:0]       data_q;
    logic                        datavalid_q;
    logic [1:0]                  header_q;
    logic                        header_valid_q;

    logic                        hdr_bad;
    logic [SH_W-1:0]             sh_inc;
    logic [INV_W-1:0]            inv_inc;

    assign hdr_bad = ~(^i_rxheader);
    assign sh_inc  = sh_cnt_q + SH_W'(1);
    assign inv_inc = inv_cnt_q + INV_W'(hdr_bad);

    // The slip pulse, counter bump and lock drop are registered on entry to SLIP
    // so they are visible during the SLIP cycle itself.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        slip_d     = 1'b0;
        slip_cnt_d = slip_cnt_q;
        case (state_q)
            ST_TEST: begin
                if (i_rxheader_valid) begin
                    if ((!lock_q && hdr_bad) || (lock_q && inv_inc == INV_MAX)) begin
                        state_d = ST_SLIP;
                        lock_d  = 1'b0;
                        slip_d  = 1'b1;
                        if (slip_cnt_q != '1) begin
                            slip_cnt_d = slip_cnt_q + SLIP_COUNT_WIDTH'(1);
                        end
                    end else if (sh_inc == LOCK_MAX) begin
                        lock_d    = 1'b1;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d  = sh_inc;
                        inv_cnt_d = lock_q ? inv_inc : '0;
                    end
                end
            end
            ST_SLIP: begin
                sh_cnt_d   = '0;
                inv_cnt_d  = '0;
                wait_cnt_d = WAIT_LOAD;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_d == '0) begin
                    state_d   = ST_TEST;
                    sh_cnt_d  = '0;
                    inv_cnt_d = '0;
                end
            end
            default: state_d = ST_TEST;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_TEST;
            lock_q         <= 1'b0;
            sh_cnt_q       <= '0;
            inv_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            slip_q         <= 1'b0;
            slip_cnt_q     <= '0;
            data_q         <= '0;
            datavalid_q    <= 1'b0;
            header_q       <= 2'b00;
            header_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lock_q         <= lock_d;
            sh_cnt_q       <= sh_cnt_d;
            inv_cnt_q      <= inv_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            slip_q         <= slip_d;
            slip_cnt_q     <= slip_cnt_d;
            data_q         <= i_rxdata;
            datavalid_q    <= i_rxdatavalid & lock_q;
            header_q       <= i_rxheader;
            header_valid_q <= i_rxheader_valid & lock_q;
        end
    end

    assign o_rxslip         = slip_q;
    assign o_block_lock     = lock_q;
    assign o_rxdata         = data_q;
    assign o_rxdatavalid    = datavalid_q;
    assign o_rxheader       = header_q;
    assign o_rxheader_valid = header_valid_q;
    assign o_slip_count     = slip_cnt_q;

endmodule

// File: tb/tb_eth_10g_block_sync.sv
// tb/tb_eth_10g_block_sync.sv - scoreboard bench for eth_10g_block_sync
module tb_eth_10g_block_sync;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_rxdata = '0;
    logic        i_rxdatavalid = 1'b0;
    logic [1:0]  i_rxheader = 2'b00;
    logic        i_rxheader_valid = 1'b0;

    logic        o_rxslip, o_block_lock, o_rxdatavalid, o_rxheader_valid;
    logic [31:0] o_rxdata;
    logic [1:0]  o_rxheader;
    logic [15:0] o_slip_count;

    logic        s_rxslip, s_block_lock, s_rxdatavalid, s_rxheader_valid;
    logic [31:0] s_rxdata;
    logic [1:0]  s_rxheader;
    logic [2:0]  s_slip_count;

    always #5 clk = ~clk;

    eth_10g_block_sync dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_rxdata(i_rxdata), .i_rxdatavalid(i_rxdatavalid),
        .i_rxheader(i_rxheader), .i_rxheader_valid(i_rxheader_valid),
        .o_rxslip(o_rxslip), .o_block_lock(o_block_lock),
        .o_rxdata(o_rxdata), .o_rxdatavalid(o_rxdatavalid),
        .o_rxheader(o_rxheader), .o_rxheader_valid(o_rxheader_valid),
        .o_slip_count(o_slip_count)
    );

    // Small counter and short wait: a constant invalid header slips every 4 cycles.
    eth_10g_block_sync #(.SLIP_WAIT_CYCLES(2), .SLIP_COUNT_WIDTH(3)) dut_sat (
        .i_clk(clk), .i_rst(i_rst),
        .i_rxdata(32'h0), .i_rxdatavalid(1'b0),
        .i_rxheader(2'b11), .i_rxheader_valid(1'b1),
        .o_rxslip(s_rxslip), .o_block_lock(s_block_lock),
        .o_rxdata(s_rxdata), .o_rxdatavalid(s_rxdatavalid),
        .o_rxheader(s_rxheader), .o_rxheader_valid(s_rxheader_valid),
        .o_slip_count(s_slip_count)
    );

    typedef struct packed {
        logic        slip;
        logic        lock;
        logic [15:0] cnt;
        logic [31:0] data;
        logic        dv;
        logic [1:0]  hdr;
        logic        hv;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          rec_n = 0;
    logic        exp_lock = 1'b0;
    logic [15:0] exp_cnt = '0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = '{o_rxslip, o_block_lock, o_slip_count, o_rxdata, o_rxdatavalid, o_rxheader, o_rxheader_valid};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL out_rec#%0d got slip=%b lock=%b cnt=%0d data=%h dv=%b hdr=%b hv=%b need slip=%b lock=%b cnt=%0d data=%h dv=%b hdr=%b hv=%b",
                         rec_n, a.slip, a.lock, a.cnt, a.data, a.dv, a.hdr, a.hv,
                         e.slip, e.lock, e.cnt, e.data, e.dv, e.hdr, e.hv);
            end
            rec_n++;
        end
    end

    // One input cycle; nlock/nslip are the hand-derived lock and slip outputs after this edge.
    task automatic cyc(input logic rst, input logic [1:0] h, input logic hv,
                       input logic nlock, input logic nslip);
        logic [31:0] d;
        logic        dv;
        exp_t        e;
        d  = $urandom;
        dv = 1'($urandom_range(0, 1));
        #1;
        i_rst = rst; i_rxdata = d; i_rxdatavalid = dv; i_rxheader = h; i_rxheader_valid = hv;
        if (rst) begin
            e = '0;
            exp_lock = 1'b0;
            exp_cnt = '0;
        end else begin
            e.data = d;
            e.hdr  = h;
            e.dv   = dv & exp_lock;
            e.hv   = hv & exp_lock;
            exp_lock = nlock;
            if (nslip) exp_cnt = exp_cnt + 16'd1;
            e.slip = nslip;
            e.lock = nlock;
            e.cnt  = exp_cnt;
        end
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    function automatic logic [1:0] good(input int i);
        return (i % 2) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] bad(input int i);
        return (i % 2) ? 2'b11 : 2'b00;
    endfunction

    // SLIP cycle plus the wait window: invalid headers here must not trigger anything.
    task automatic ignore(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, bad(i), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, good(i), 1'b1, i == 63, 1'b0);
            cyc(1'b0, 2'b11, 1'b0, exp_lock, 1'b0);
        end

        for (int w = 0; w < 2; w++)
            for (int j = 0; j < 64; j++)
                cyc(1'b0, (j < 15) ? bad(j) : good(j), 1'b1, 1'b1, 1'b0);

        for (int j = 0; j < 16; j++) cyc(1'b0, bad(j), 1'b1, j != 15, j == 15);
        ignore(33);

        for (int i = 0; i < 64; i++) cyc(1'b0, good(i), 1'b1, i == 63, 1'b0);

        for (int j = 0; j < 64; j++)
            cyc(1'b0, (j < 48) ? good(j) : bad(j), 1'b1, j != 63, j == 63);
        ignore(33);

        for (int i = 0; i < 9; i++) cyc(1'b0, good(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
        ignore(33);
        for (int i = 0; i < 64; i++) cyc(1'b0, good(i), 1'b1, i == 63, 1'b0);

        for (int i = 0; i < 20; i++) cyc(1'b0, good(i), 1'($urandom_range(0, 1)), 1'b1, 1'b0);

        for (int j = 0; j < 16; j++) cyc(1'b0, bad(j), 1'b1, j != 15, j == 15);
        ignore(5);
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        ignore(33);
        for (int i = 0; i < 10; i++) cyc(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d pending need 0", exp_q.size());
        end
        tests++;
        if (s_slip_count !== 3'd7) begin
            fails++;
            $display("FAIL slip_saturate got %0d need 7", s_slip_count);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_10g_block_sync.md
# eth_10g_block_sync

10GBASE-R receive block synchroniser (IEEE 802.3 Clause 49 block-lock) that sits directly downstream of the GTX lane wrapper in the 10G receive path. It inspects each 2-bit sync header from the GTX gearbox and pulses the wrapper's rxslip input until header alignment is found. It reports block lock and forwards the data/header stream one cycle later, with data valid forced low while unlocked. It runs on the GTX recovered user clock.

## Interface

Parameters:
- DATA_WIDTH, 32: width of the data word from the gearbox.
- LOCK_COUNT, 64: consecutive valid headers required to acquire lock; also the size of the invalid-header test window while locked.
- INVALID_LIMIT, 16: invalid headers within one window that cause loss of lock.
- SLIP_WAIT_CYCLES, 32: cycles during which headers are ignored after an rxslip pulse. Must be ≥ 1.
- SLIP_COUNT_WIDTH, 16: width of the slip counter.

Ports:
- i_clk  in  1  GTX receive user clock. This is the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rxdata  in  DATA_WIDTH  gearbox data word.
- i_rxdatavalid  in  1  i_rxdata is valid this cycle.
- i_rxheader  in  2  sync header.
- i_rxheader_valid  in  1  i_rxheader is valid this cycle.
- o_rxslip  out  1  one-cycle slip request to the GTX.
- o_block_lock  out  1  block lock status.
- o_rxdata  out  DATA_WIDTH  i_rxdata delayed by 1 cycle.
- o_rxdatavalid  out  1  delayed i_rxdatavalid, gated by lock.
- o_rxheader  out  2  i_rxheader delayed by 1 cycle.
- o_rxheader_valid  out  1  delayed i_rxheader_valid, gated by lock.
- o_slip_count  out  SLIP_COUNT_WIDTH  number of slips since reset; saturates at all-ones.

## Operation

- A header is **valid** when it is 2'b01 or 2'b10. Values 2'b00 and 2'b11 are **invalid**.
- A header is **tested** only when i_rxheader_valid=1 and the state is TEST.
- Internal counters:
  - sh_cnt, range 0..LOCK_COUNT: headers tested in the current window.
  - inv_cnt, range 0..INVALID_LIMIT: invalid headers in the current window.
- States:
  - **TEST**: entered from reset. On each tested header:
    - Unlocked, header invalid: go to SLIP.
    - Unlocked, header valid: sh_cnt++. When sh_cnt reaches LOCK_COUNT, set lock=1 and clear both counters.
    - Locked: sh_cnt++, and inv_cnt++ if the header is invalid.
      - If inv_cnt reaches INVALID_LIMIT: set lock=0 and go to SLIP. This has priority, including when sh_cnt reaches LOCK_COUNT on the same header.
      - Otherwise, if sh_cnt reaches LOCK_COUNT: clear both counters and stay locked.
  - **SLIP**: lasts one cycle.
    - o_rxslip=1.
    - o_slip_count++ (saturating).
    - Counters cleared; wait counter loaded with SLIP_WAIT_CYCLES.
    - Go to WAIT.
  - **WAIT**: decrement the wait counter each cycle; all headers are ignored, valid or not. At zero, go to TEST with counters cleared.
- Passthrough registers update every cycle:
  - o_rxdata and o_rxheader copy their inputs unconditionally.
  - o_rxdatavalid = i_rxdatavalid & lock, and o_rxheader_valid = i_rxheader_valid & lock. "lock" is the lock value at the start of the cycle, i.e. before that cycle's update.

## Timing

- Reset values (one cycle after i_rst is sampled high):
  - o_rxslip=0, o_block_lock=0, o_rxdata=0, o_rxdatavalid=0, o_rxheader=0, o_rxheader_valid=0, o_slip_count=0.
  - State=TEST, all counters 0.
- Lock acquisition: o_block_lock rises in the cycle after the LOCK_COUNT-th consecutive valid header is sampled.
- Slip:
  - Let cycle N be the cycle after the triggering header is sampled.
  - o_rxslip is high during cycle N only; o_slip_count increments in the same cycle.
  - Loss of lock: o_block_lock falls in cycle N.
  - Headers presented during cycles N+1 .. N+SLIP_WAIT_CYCLES are ignored.
  - The first tested header is the one at cycle N+SLIP_WAIT_CYCLES+1.
- o_rxslip is never high on two consecutive cycles.
- Passthrough latency is exactly 1 cycle.
- Reset asserted in any state, including SLIP or WAIT, overrides everything and restores the reset values.

## Test plan

- **Acquire lock:** reset, then 64 valid headers alternating 01/10, one per 2 cycles → o_block_lock=1 the cycle after the 64th header; o_rxslip never asserted; o_slip_count=0.
- **Slip while unlocked:** unlocked; headers 1–9 valid, header 10 = 2'b11 → single o_rxslip pulse, o_slip_count=1. Invalid headers during the 32 wait cycles are ignored (no further pulse). Then 64 valid headers → lock.
- **Hold lock at the limit:** locked; inject 15 invalid headers in each of two consecutive 64-header windows → o_block_lock stays 1; no slip.
- **Lose lock:** locked; inject 16 invalid headers within one window, including a case where the 16th invalid header is also the 64th header of the window → o_block_lock=0 and o_rxslip=1 the cycle after the 16th invalid header; o_rxdatavalid=0 from the following cycle.
- **Data gating:** random i_rxdata/i_rxdatavalid → o_rxdatavalid and o_rxheader_valid are 0 while unlocked. While locked, all passthrough outputs equal the inputs delayed by 1 cycle.
- **Reset and saturation:** assert i_rst during WAIT → all outputs take reset values the next cycle. Separately, force more than 2^SLIP_COUNT_WIDTH slips (small SLIP_COUNT_WIDTH=3) → o_slip_count holds at 7.
